// File: rtl/itr_ctrl_if.sv
// Core-side bus of the interrupt controller: request lines, I/O output strobe and status outputs.
interface itr_ctrl_if #(
  parameter int unsigned NUBITS = 32,
  parameter int unsigned NUITRS = 4,
  parameter int unsigned NUIOOU = 8
);
  logic [NUITRS-1:0]          irq_src;
  logic                       out_en;
  logic [$clog2(NUIOOU)-1:0]  addr_out;
  logic [NUBITS-1:0]          data_out;
  logic                       itr;
  logic [NUBITS-1:0]          itr_id;
  logic                       busy;
  logic                       tmo_err;

  modport master (
    output irq_src, out_en, addr_out, data_out,
    input  itr, itr_id, busy, tmo_err
  );

  modport slave (
    input  irq_src, out_en, addr_out, data_out,
    output itr, itr_id, busy, tmo_err
  );
endinterface

// File: rtl/itr_ctrl.sv
// Priority interrupt controller: synchronised edge detect, pending/mask registers, one-cycle itr pulse.
// Optional service timeout is enabled by defining ITR_TIMEOUT_EN.
module itr_ctrl #(
  parameter int unsigned NUBITS = 32,
  parameter int unsigned NUITRS = 4,
  parameter int unsigned NUIOOU = 8,
  parameter int unsigned MSKADD = 6,
  parameter int unsigned ACKADD = 7,
  parameter int unsigned TMOUT  = 255
) (
  input logic       clk,
  input logic       rst,
  itr_ctrl_if.slave bus
);

  localparam int unsigned AW  = $clog2(NUIOOU);
  localparam int unsigned IdW = $clog2(NUITRS);
  localparam logic [AW-1:0] MskAddr = AW'(MSKADD);
  localparam logic [AW-1:0] AckAddr = AW'(ACKADD);

  typedef enum logic [1:0] {StIdle, StFire, StService} state_e;

  state_e            state_q, state_d;
  logic [NUITRS-1:0] s1_q, s2_q, pend_q, pend_d, mask_q, rise, req, ack_clr;
  logic [IdW-1:0]    cur_id_q, cur_id_d, sel_id;
  logic              mask_wr, ack_wr, clr_cur;
  logic              unused_data;

  assign unused_data = ^bus.data_out[NUBITS-1:NUITRS];

  assign rise    = s1_q & ~s2_q;
  assign req     = pend_q & mask_q;
  assign mask_wr = bus.out_en && (bus.addr_out == MskAddr);
  assign ack_wr  = bus.out_en && (bus.addr_out == AckAddr) && (state_q == StService);

`ifdef ITR_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TMOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_hit, tmo_err_q;

  // Ack takes priority over a timeout landing in the same cycle.
  assign tmo_hit = (state_q == StService) && !ack_wr && (cnt_q == CntW'(TMOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StFire) begin
      cnt_d = '0;
    end else if (state_q == StService) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_q | tmo_hit;
    end
  end

  assign bus.tmo_err = tmo_err_q;
`else
  logic tmo_hit;
  assign tmo_hit     = 1'b0;
  assign bus.tmo_err = 1'b0;
`endif

  // Lowest set index wins.
  always_comb begin
    sel_id = '0;
    for (int i = NUITRS - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_id = IdW'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    clr_cur  = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d  = StFire;
          cur_id_d = sel_id;
        end
      end
      StFire: state_d = StService;
      StService: begin
        if (ack_wr || tmo_hit) begin
          state_d = StIdle;
          clr_cur = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new rise on the in-service source overrides its clear.
  always_comb begin
    ack_clr = '0;
    if (clr_cur) begin
      ack_clr[cur_id_q] = 1'b1;
    end
    pend_d = (pend_q & ~ack_clr) | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      s1_q     <= '0;
      s2_q     <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      cur_id_q <= '0;
    end else begin
      state_q  <= state_d;
      s1_q     <= bus.irq_src;
      s2_q     <= s1_q;
      pend_q   <= pend_d;
      cur_id_q <= cur_id_d;
      if (mask_wr) begin
        mask_q <= bus.data_out[NUITRS-1:0];
      end
    end
  end

  assign bus.itr    = (state_q == StFire);
  assign bus.busy   = (state_q != StIdle);
  assign bus.itr_id = NUBITS'(cur_id_q);

endmodule

// File: tb/tb_itr_ctrl.sv
// Directed testbench for itr_ctrl; timeout checks depend on ITR_TIMEOUT_EN.
module tb_itr_ctrl;
  localparam int unsigned NUBITS = 32;
  localparam int unsigned NUITRS = 4;
  localparam int unsigned NUIOOU = 8;
  localparam logic [2:0] MSK = 3'd6;
  localparam logic [2:0] ACK = 3'd7;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   itr_seen;

  itr_ctrl_if #(.NUBITS(NUBITS), .NUITRS(NUITRS), .NUIOOU(NUIOOU)) bus ();

  itr_ctrl #(
    .NUBITS(NUBITS),
    .NUITRS(NUITRS),
    .NUIOOU(NUIOOU),
    .MSKADD(6),
    .ACKADD(7),
    .TMOUT (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    bus.out_en   = 1'b1;
    bus.addr_out = addr;
    bus.data_out = data;
    step();
    bus.out_en   = 1'b0;
    bus.data_out = '0;
  endtask

  // Pulse for one cycle; pend is set two edges later.
  task automatic pulse(input logic [3:0] src);
    bus.irq_src = src;
    step();
    bus.irq_src = '0;
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst          = 1'b0;
    bus.irq_src  = '0;
    bus.out_en   = 1'b0;
    bus.addr_out = '0;
    bus.data_out = '0;
    step();
    step();
    check("rst_itr", bus.itr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_id", bus.itr_id, 0);
    check("rst_tmo", bus.tmo_err, 0);
    rst = 1'b1;
    step();

    // Single source, exact latency
    wr(MSK, 32'hF);
    bus.irq_src = 4'b0100;
    step();
    bus.irq_src = '0;
    check("lat_e1_itr", bus.itr, 0);
    step();
    check("lat_e2_itr", bus.itr, 0);
    check("lat_e2_busy", bus.busy, 0);
    step();
    check("lat_e3_itr", bus.itr, 1);
    check("lat_e3_id", bus.itr_id, 2);
    check("lat_e3_busy", bus.busy, 1);
    step();
    check("svc_itr", bus.itr, 0);
    check("svc_busy", bus.busy, 1);
    step();
    wr(ACK, 0);
    check("ack_busy", bus.busy, 0);
    check("ack_id_hold", bus.itr_id, 2);

    // Two sources together: priority, ack ignored in FIRE
    bus.irq_src = 4'b1010;
    step();
    bus.irq_src = '0;
    step();
    step();
    check("pri_itr", bus.itr, 1);
    check("pri_id", bus.itr_id, 1);
    wr(ACK, 0);
    check("fire_ack_ign", bus.busy, 1);
    check("fire_ack_itr", bus.itr, 0);
    wr(ACK, 0);
    check("pri_ack_busy", bus.busy, 0);
    check("pri_ack_itr", bus.itr, 0);
    step();
    check("pri2_itr", bus.itr, 1);
    check("pri2_id", bus.itr_id, 3);
    step();
    wr(ACK, 0);
    step();
    step();
    check("pri_done", bus.busy, 0);

    // Masked request held pending until mask write
    wr(MSK, 32'h0);
    pulse(4'b0001);
    step();
    step();
    check("mask0_itr", bus.itr, 0);
    check("mask0_busy", bus.busy, 0);
    wr(MSK, 32'h1);
    check("mskwr_e1_itr", bus.itr, 0);
    step();
    check("mskwr_e2_itr", bus.itr, 1);
    check("mskwr_e2_id", bus.itr_id, 0);
    step();
    wr(MSK, 32'hF);
    check("mskchg_id", bus.itr_id, 0);
    check("mskchg_busy", bus.busy, 1);
    wr(ACK, 0);
    step();
    step();
    check("mask_done", bus.busy, 0);

    // Rise on in-service source coincident with ack
    pulse(4'b0100);
    step();
    check("coin_fire", bus.itr, 1);
    check("coin_id", bus.itr_id, 2);
    step();
    bus.irq_src = 4'b0100;
    step();
    bus.irq_src = '0;
    wr(ACK, 0);
    check("coin_ack_busy", bus.busy, 0);
    step();
    check("coin_refire", bus.itr, 1);
    check("coin_reid", bus.itr_id, 2);
    step();
    wr(ACK, 0);
    step();
    step();
    check("coin_done", bus.busy, 0);

`ifdef ITR_TIMEOUT_EN
    pulse(4'b0010);
    step();
    check("tmo_fire", bus.itr, 1);
    step();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tmo_svc%0d", i), bus.busy, 1);
      step();
    end
    check("tmo_busy", bus.busy, 0);
    check("tmo_err", bus.tmo_err, 1);
    step();
    step();
    check("tmo_noretry", bus.busy, 0);
    wr(ACK, 0);
    check("tmo_ack_idle", bus.busy, 0);
    check("tmo_sticky", bus.tmo_err, 1);
`else
    pulse(4'b0010);
    step();
    check("wait_fire", bus.itr, 1);
    for (int i = 0; i < 20; i++) begin
      step();
    end
    check("wait_busy", bus.busy, 1);
    check("wait_tmo", bus.tmo_err, 0);
    wr(ACK, 0);
    check("wait_ack", bus.busy, 0);
`endif

    // Reset mid-service with other sources pending
    pulse(4'b1000);
    step();
    step();
    pulse(4'b0011);
    check("mrst_pre_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    check("mrst_itr", bus.itr, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_id", bus.itr_id, 0);
    check("mrst_tmo", bus.tmo_err, 0);
    step();
    rst = 1'b1;
    step();
    wr(MSK, 32'hF);
    itr_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.itr || bus.busy) itr_seen++;
      step();
    end
    check("mrst_no_itr", itr_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/itr_ctrl.md
ITR_CTRL -- requirements
Module: itr_ctrl

Interface
REQ-001 The block SHALL provide parameter NUBITS, default 32, the core data word width.
REQ-002 The block SHALL provide parameter NUITRS, default 4, the number of interrupt sources (min 2).
REQ-003 The block SHALL provide parameter NUIOOU, default 8, the number of core output I/O addresses.
REQ-004 The block SHALL provide parameter MSKADD, default 6, the output I/O address that writes the mask register.
REQ-005 The block SHALL provide parameter ACKADD, default 7, the output I/O address that acknowledges the in-service interrupt.
REQ-006 The block SHALL provide parameter TMOUT, default 255, the service timeout in cycles (used only under ITR_TIMEOUT_EN).
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock, rising-edge active.
REQ-008 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-low.
REQ-009 The block SHALL have port irq_src, input, NUITRS bits, asynchronous interrupt request lines.
REQ-010 The block SHALL have port out_en, input, 1 bit, the core output strobe.
REQ-011 The block SHALL have port addr_out, input, $clog2(NUIOOU) bits, the core output address.
REQ-012 The block SHALL have port data_out, input, NUBITS bits, the core output data.
REQ-013 The block SHALL have port itr, output, 1 bit, the interrupt pulse to the core.
REQ-014 The block SHALL have port itr_id, output, NUBITS bits, the zero-extended index of the in-service source, readable by the core through io_in.
REQ-015 The block SHALL have port busy, output, 1 bit, high while the FSM is not in IDLE.
REQ-016 The block SHALL have port tmo_err, output, 1 bit, the sticky timeout flag.

Function
REQ-017 Each irq_src bit SHALL pass through a 2-flop synchronizer (s1, s2); a rise SHALL be detected as s1 & ~s2.
REQ-018 A detected rise SHALL set pend[i] at the same edge that updates s2, whether or not mask[i] is set.
REQ-019 The FSM SHALL have states IDLE, FIRE and SERVICE.
REQ-020 IDLE -> FIRE when (pend & mask) != 0; at that edge cur_id SHALL latch the lowest set index of pend & mask (index 0 = highest priority).
REQ-021 itr SHALL be high for exactly the one cycle spent in FIRE; FIRE -> SERVICE unconditionally.
REQ-022 Latency: irq_src high before edge 1 -> pend set at edge 2 -> FIRE at edge 3 -> itr high for cycle 3-4, with mask already set.
REQ-023 In SERVICE, out_en && addr_out==ACKADD SHALL clear pend[cur_id] and return to IDLE at the same edge.
REQ-024 An ACKADD write in IDLE or FIRE SHALL be ignored.
REQ-025 If a new rise on source cur_id coincides with its ack, set SHALL win and pend[cur_id] SHALL stay 1.
REQ-026 out_en && addr_out==MSKADD SHALL load mask <= data_out[NUITRS-1:0] in any state; a mask change SHALL NOT affect the in-service cur_id.
REQ-027 itr_id SHALL equal cur_id, zero-extended to NUBITS, held constant from FIRE until the next FIRE.
REQ-028 After an ack, another pending enabled source SHALL enter FIRE no earlier than the edge following the return to IDLE.
REQ-029 Only one interrupt SHALL be in service at a time; no nesting.

Reset
REQ-030 While rst==0 (asynchronous), the block SHALL force state=IDLE, s1=s2=0, pend=0, mask=0 (all disabled), cur_id=0, itr=0, itr_id=0, busy=0 and tmo_err=0.
REQ-031 If reset is asserted mid-service, the in-service interrupt and all pending requests SHALL be discarded with no itr pulse afterwards.

Configuration
REQ-032 With macro ITR_TIMEOUT_EN defined, a counter SHALL clear on entry to SERVICE and increment each SERVICE cycle; on reaching TMOUT without ack, the FSM SHALL go to IDLE, clear pend[cur_id] and set tmo_err.
REQ-033 tmo_err SHALL be cleared only by reset.
REQ-034 Without ITR_TIMEOUT_EN, no counter SHALL exist, SERVICE SHALL wait indefinitely for ack, and tmo_err SHALL be tied to 0.

Verification
REQ-035 Write mask=4'b1111, then pulse irq_src[2] -> itr high exactly one cycle, 3 cycles after sampling; itr_id=2; busy=1.
REQ-036 Raise irq_src[3] and irq_src[1] on the same edge -> first FIRE with itr_id=1; after ack at ACKADD, second FIRE with itr_id=3.
REQ-037 Mask=0, pulse irq_src[0] -> no itr; then write mask=1 -> itr with itr_id=0 on the 2nd edge after the mask write.
REQ-038 While source 2 is in SERVICE, give a new rise on irq_src[2] coincident with the ack -> pend[2] stays set and a second FIRE follows with itr_id=2.
REQ-039 ITR_TIMEOUT_EN defined, TMOUT=8: fire with no ack -> busy drops after 8 SERVICE cycles, tmo_err=1; ack in IDLE is ignored.
REQ-040 Assert rst low during SERVICE with pending sources -> all outputs reach their reset values immediately; after release, no itr occurs.
